// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the alu_ctrl slice.
//   op_t    - 3-bit opcode encoding driven on cmd_op
//   state_t - alu_ctrl sequencing states
//   DATA_W  - operand/result width
//   REGS    - register-file depth, REG_AW its address width
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int REGS   = 8;
    localparam int REG_AW = $clog2(REGS);

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/alu16.sv
// alu16: combinational ALU core.
//   a, b : operands (W bits)
//   op   : opcode (op_t encoding)
//   y    : result, modulo 2^W
//   c    : carry/borrow/shifted-out bit, only present with ALU_CTRL_FLAGS_EN
// Logic ops and NOT report c = 0. SUB reports the borrow (1 when a < b unsigned).
module alu16
    import alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
`ifdef ALU_CTRL_FLAGS_EN
    output logic         c,
`endif
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
`ifdef ALU_CTRL_FLAGS_EN
        c = 1'b0;
`endif
        case (op_t'(op))
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: begin
`ifdef ALU_CTRL_FLAGS_EN
                {c, y} = {1'b0, a} + {1'b0, b};
`else
                y = a + b;
`endif
            end
            OP_SUB: begin
                // The extra top bit of a (W+1)-bit difference is the borrow.
`ifdef ALU_CTRL_FLAGS_EN
                {c, y} = {1'b0, a} - {1'b0, b};
`else
                y = a - b;
`endif
            end
            OP_NOT: y = ~a;
            OP_SHL: begin
                y = {a[W-2:0], 1'b0};
`ifdef ALU_CTRL_FLAGS_EN
                c = a[W-1];
`endif
            end
            OP_SHR: begin
                y = {1'b0, a[W-1:1]};
`ifdef ALU_CTRL_FLAGS_EN
                c = a[0];
`endif
            end
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: multi-cycle control unit around alu16 with an internal register file.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; transfer when both are high
//   cmd_op, cmd_rd/ra/rb: opcode, destination and source registers
//   load_valid/addr/data: direct register write, honoured only in IDLE
//   dbg_addr / dbg_data : combinational register-file read port
//   done                : one-cycle pulse in the WRITE state
//   result, zero, carry : last written result and its flags
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is only high in IDLE with no load
// pending, so a simultaneous load always wins and the command waits.
// Sequence per command: IDLE -> READ -> EXEC -> WRITE -> IDLE (4 cycles).
// Build option ALU_CTRL_FLAGS_EN: when defined, zero/carry are registered at
// WRITE; when undefined, the flag logic is absent and both outputs read 0.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REGS   = alu_pkg::REGS,
    localparam int AW    = $clog2(REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_ra,
    input  logic [AW-1:0]     cmd_rb,
    input  logic              load_valid,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    state_t            state;
    state_t            state_nx;

    logic [2:0]        op_q;
    logic [AW-1:0]     rd_q;
    logic [AW-1:0]     ra_q;
    logic [AW-1:0]     rb_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] regs [REGS];
    logic [DATA_W-1:0] alu_y;

`ifdef ALU_CTRL_FLAGS_EN
    logic              alu_c;
    logic              c_q;
    logic              zero_q;
    logic              carry_q;
`endif

    alu16 #(.W(DATA_W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
`ifdef ALU_CTRL_FLAGS_EN
        .c  (alu_c),
`endif
        .y  (alu_y)
    );

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !load_valid;
                if (cmd_valid && !load_valid) state_nx = S_READ;
            end
            S_READ:  state_nx = S_EXEC;
            S_EXEC:  state_nx = S_WRITE;
            S_WRITE: begin
                // A reset landing on WRITE suppresses the write-back, so the
                // pulse is suppressed with it.
                done     = !rst;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            result_q <= '0;
`ifdef ALU_CTRL_FLAGS_EN
            c_q      <= 1'b0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_valid) begin
                        regs[load_addr] <= load_data;
                    end else if (cmd_valid) begin
                        op_q <= cmd_op;
                        rd_q <= cmd_rd;
                        ra_q <= cmd_ra;
                        rb_q <= cmd_rb;
                    end
                end
                S_READ: begin
                    // Operands are captured before this command's write-back,
                    // so ra/rb == rd always sees the old value.
                    a_q <= regs[ra_q];
                    b_q <= regs[rb_q];
                end
                S_EXEC: begin
                    res_q <= alu_y;
`ifdef ALU_CTRL_FLAGS_EN
                    c_q   <= alu_c;
`endif
                end
                S_WRITE: begin
                    regs[rd_q] <= res_q;
                    result_q   <= res_q;
`ifdef ALU_CTRL_FLAGS_EN
                    zero_q     <= (res_q == '0);
                    carry_q    <= c_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign dbg_data = regs[dbg_addr];
    assign result   = result_q;

`ifdef ALU_CTRL_FLAGS_EN
    assign zero  = zero_q;
    assign carry = carry_q;
`else
    assign zero  = 1'b0;
    assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed bench for alu_ctrl.
// Drivers present commands and loads on the falling edge; every accepted
// command pushes its hand-computed result, flags and acceptance cycle into
// the scoreboard queues. A monitor samples just after each falling edge,
// pops an entry on every done pulse, checks the latency immediately and the
// result/flags one cycle later (they update on the WRITE edge).
module tb_alu_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_ra;
    logic [2:0]  cmd_rb;
    logic        load_valid;
    logic [2:0]  load_addr;
    logic [15:0] load_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        done;
    logic [15:0] result;
    logic        zero;
    logic        carry;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] exp_q[$];
    logic        exp_z_q[$];
    logic        exp_c_q[$];
    int          exp_cyc_q[$];

    logic        gap_chk = 1'b0;
    int          gap     = 0;

    alu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_ra     (cmd_ra),
        .cmd_rb     (cmd_rb),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .carry      (carry)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic flag(input logic v);
`ifdef ALU_CTRL_FLAGS_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        @(negedge clk);
        load_valid = 1'b0;
        dbg_addr   = addr;
        #1;
        check($sformatf("load_r%0d", addr), dbg_data, data);
    endtask

    // Presents a command (cmd_valid stays high on return) and waits for the
    // accepting edge; push=0 issues a command that is expected to be aborted.
    task automatic do_cmd(input string name, input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb,
                          input logic [15:0] exp_res, input logic exp_c, input logic push);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_ra    = ra;
        cmd_rb    = rb;
        #1;
        for (int t = 0; t < 20 && !cmd_ready; t++) begin
            @(negedge clk);
            #1;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_handshake: cmd_ready never rose, got %b, expected 1", name, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        if (push) begin
            exp_q.push_back(exp_res);
            exp_z_q.push_back(flag(exp_res == 16'h0000));
            exp_c_q.push_back(flag(exp_c));
            exp_cyc_q.push_back(cyc);
        end
        @(posedge clk);
    endtask

    task automatic release_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done_dbg(input string name, input logic [2:0] rd, input logic [15:0] exp);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            #1;
            seen = done;
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        dbg_addr = rd;
        #1;
        check({name, "_dbg"}, dbg_data, exp);
    endtask

    task automatic single(input string name, input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb,
                          input logic [15:0] exp_res, input logic exp_c);
        do_cmd(name, op, rd, ra, rb, exp_res, exp_c, 1'b1);
        release_cmd();
        wait_done_dbg(name, rd, exp_res);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        pend = 1'b0;
    logic [15:0] pend_res;
    logic        pend_z;
    logic        pend_c;

    always @(negedge clk) begin
        #1;
        if (pend) begin
            check("sb_result", result, pend_res);
            check("sb_zero", {31'd0, zero}, {31'd0, pend_z});
            check("sb_carry", {31'd0, carry}, {31'd0, pend_c});
            pend = 1'b0;
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                pend_res = exp_q.pop_front();
                pend_z   = exp_z_q.pop_front();
                pend_c   = exp_c_q.pop_front();
                check("sb_latency", cyc, exp_cyc_q.pop_front() + 3);
                pend = 1'b1;
            end
        end
        if (gap_chk) begin
            if (!cmd_ready) begin
                gap++;
            end else if (gap > 0) begin
                check("ready_gap", gap, 3);
                gap = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_rd     = '0;
        cmd_ra     = '0;
        cmd_rb     = '0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        dbg_addr   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 16'h0000);
        check("rst_zero", {31'd0, zero}, {31'd0, flag(1'b1)});
        check("rst_carry", {31'd0, carry}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("rst_dbg_r%0d", i), dbg_data, 16'h0000);
        end

        do_load(3'd1, 16'hFFFF);
        do_load(3'd2, 16'hAAAA);
        single("and_r3", OP_AND, 3'd3, 3'd1, 3'd2, 16'hAAAA, 1'b0);
        do_load(3'd4, 16'h5555);
        single("and_r5", OP_AND, 3'd5, 3'd4, 3'd2, 16'h0000, 1'b0);
        single("add_r6", OP_ADD, 3'd6, 3'd1, 3'd1, 16'hFFFE, 1'b1);
        single("sub_r7", OP_SUB, 3'd7, 3'd2, 3'd1, 16'hAAAB, 1'b1);

        // Load and command together: load wins, command follows next cycle.
        @(negedge clk);
        load_valid = 1'b1;
        load_addr  = 3'd0;
        load_data  = 16'h0F0F;
        cmd_valid  = 1'b1;
        cmd_op     = OP_AND;
        cmd_rd     = 3'd3;
        cmd_ra     = 3'd0;
        cmd_rb     = 3'd1;
        #1;
        check("prio_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        load_valid = 1'b0;
        dbg_addr   = 3'd0;
        #1;
        check("prio_ready_high", {31'd0, cmd_ready}, 32'd1);
        check("prio_load_first", dbg_data, 16'h0F0F);
        exp_q.push_back(16'h0F0F);
        exp_z_q.push_back(flag(1'b0));
        exp_c_q.push_back(flag(1'b0));
        exp_cyc_q.push_back(cyc);
        @(posedge clk);
        release_cmd();
        wait_done_dbg("prio_and_r3", 3'd3, 16'h0F0F);

        // Back-to-back commands with cmd_valid held high throughout.
        @(negedge clk);
        gap     = 0;
        gap_chk = 1'b1;
        do_cmd("b2b_or",   OP_OR,  3'd0, 3'd4, 3'd2, 16'hFFFF, 1'b0, 1'b1);
        do_cmd("b2b_xor",  OP_XOR, 3'd0, 3'd1, 3'd4, 16'hAAAA, 1'b0, 1'b1);
        do_cmd("b2b_not",  OP_NOT, 3'd5, 3'd7, 3'd0, 16'h5554, 1'b0, 1'b1);
        do_cmd("b2b_shl",  OP_SHL, 3'd6, 3'd2, 3'd0, 16'h5554, 1'b1, 1'b1);
        do_cmd("b2b_shr",  OP_SHR, 3'd7, 3'd4, 3'd0, 16'h2AAA, 1'b1, 1'b1);
        do_cmd("b2b_add",  OP_ADD, 3'd1, 3'd1, 3'd1, 16'hFFFE, 1'b1, 1'b1);
        do_cmd("b2b_sub",  OP_SUB, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1);
        release_cmd();
        wait_done_dbg("b2b_sub_r0", 3'd0, 16'h0000);
        repeat (2) @(negedge clk);
        gap_chk = 1'b0;
        dbg_addr = 3'd1;
        #1;
        check("b2b_r1", dbg_data, 16'hFFFE);
        dbg_addr = 3'd6;
        #1;
        check("b2b_r6", dbg_data, 16'h5554);

        // Reset while the command sits in EXEC: no done, no write-back.
        do_cmd("rst_exec", OP_ADD, 3'd2, 3'd1, 3'd1, 16'hFFFC, 1'b1, 1'b0);
        release_cmd();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        dbg_addr = 3'd2;
        #1;
        check("rst_exec_rd", dbg_data, 16'h0000);
        check("rst_exec_result", result, 16'h0000);
        check("rst_exec_ready", {31'd0, cmd_ready}, 32'd1);

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
